// File: rtl/fir_filter_tdm.sv
// Time-multiplexed float10 FIR filter: one shared multiplier and adder, sequenced tap by tap
// over per-channel sample rings that share a runtime-loadable coefficient bank.

module float_point_mult #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic [9:0] out,
    output logic       out_avl
);
    logic [11:0] prod;
    logic [9:0]  res;
    logic [2:0]  cnt;
    int          e;

    // Exact 6x6 significand product, truncated toward zero; exponent field 0 reads as zero
    always_comb begin
        prod = 12'({1'b1, a[4:0]}) * 12'({1'b1, b[4:0]});
        e    = int'(a[8:5]) + int'(b[8:5]) - 7 + (prod[11] ? 1 : 0);
        res  = '0;
        if (a[8:5] == 4'd0 || b[8:5] == 4'd0 || e < 1) res = '0;
        else if (e > 15)                                res = {a[9] ^ b[9], 4'hF, 5'h1F};
        else                                            res = {a[9] ^ b[9], 4'(e), prod[11] ? prod[10:6] : prod[9:5]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            out_avl <= 1'b0;
            cnt     <= '0;
        end else if (en) begin
            out     <= res;
            out_avl <= (LAT <= 1);
            cnt     <= (LAT <= 1) ? 3'd0 : 3'(LAT - 1);
        end else if (cnt != 3'd0) begin
            cnt     <= cnt - 3'd1;
            out_avl <= (cnt == 3'd1);
        end
    end
endmodule

module float_point_adder #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic [9:0] out,
    output logic       out_avl
);
    logic [20:0] ma;
    logic [20:0] mb;
    logic [21:0] sum;
    logic        sgn;
    logic [9:0]  res;
    logic [2:0]  cnt;
    int          msb;
    int          e;

    // Both operands scaled to a common fixed point so the sum is exact before truncation
    always_comb begin
        ma  = (a[8:5] == 4'd0) ? '0 : 21'({1'b1, a[4:0]}) << (a[8:5] - 4'd1);
        mb  = (b[8:5] == 4'd0) ? '0 : 21'({1'b1, b[4:0]}) << (b[8:5] - 4'd1);
        sgn = a[9];
        if (a[9] == b[9]) begin
            sum = {1'b0, ma} + {1'b0, mb};
        end else if (ma >= mb) begin
            sum = {1'b0, ma - mb};
        end else begin
            sum = {1'b0, mb - ma};
            sgn = b[9];
        end
        msb = 0;
        for (int i = 0; i < 22; i++) if (sum[i]) msb = i;
        e   = msb - 4;
        res = '0;
        if (e < 1)       res = '0;
        else if (e > 15) res = {sgn, 4'hF, 5'h1F};
        else             res = {sgn, 4'(e), 5'(sum >> (msb - 5))};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            out_avl <= 1'b0;
            cnt     <= '0;
        end else if (en) begin
            out     <= res;
            out_avl <= (LAT <= 1);
            cnt     <= (LAT <= 1) ? 3'd0 : 3'(LAT - 1);
        end else if (cnt != 3'd0) begin
            cnt     <= cnt - 3'd1;
            out_avl <= (cnt == 3'd1);
        end
    end
endmodule

module fir_filter_tdm #(
    parameter int unsigned TAPS     = 30,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned MUL_LAT  = 1,
    parameter int unsigned ADD_LAT  = 1,
    localparam int unsigned PW      = $clog2(TAPS),
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk_fast,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_chan,
    input  logic [9:0]    in_data,
    input  logic          coef_we,
    input  logic [PW-1:0] coef_addr,
    input  logic [9:0]    coef_data,
    output logic          out_valid,
    output logic [CW-1:0] out_chan,
    output logic [9:0]    out_data,
    output logic          busy
);
    localparam int unsigned DEPTH  = 1 << PW;
    localparam int unsigned NCH    = 1 << CW;
    localparam logic [PW:0] TAPS_X = (PW + 1)'(TAPS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
    localparam logic [2:0] S_WAIT_M = 3'd3;
    localparam logic [2:0] S_ADD    = 3'd4;
    localparam logic [2:0] S_WAIT_A = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]    state, state_nx;
    logic [9:0]    coef  [DEPTH];
    logic [9:0]    dline [NCH][DEPTH];
    logic [PW-1:0] wr_ptr [NCH];
    logic [PW-1:0] k, base, rd_idx;
    logic [PW:0]   idx_sum;
    logic [CW-1:0] chan;
    logic [9:0]    sample, acc, prod;
    logic [9:0]    mul_out, add_out;
    logic          mul_avl, add_avl, chan_ok, last_tap;

    assign in_ready = (state == S_IDLE) && !clr && !out_valid;
    assign chan_ok  = 32'(in_chan) < CHANNELS;
    assign last_tap = (k == PW'(TAPS - 1));

    // x[n-k] lives k slots behind the newest sample, wrapping around the ring
    always_comb begin
        idx_sum = {1'b0, base} + TAPS_X - {1'b0, k};
        rd_idx  = (idx_sum >= TAPS_X) ? PW'(idx_sum - TAPS_X) : PW'(idx_sum);
    end

    float_point_mult #(.LAT(MUL_LAT)) u_mult (
        .clk(clk_fast), .rst_n(rst), .en(state == S_MUL),
        .a(coef[k]), .b(dline[chan][rd_idx]), .out(mul_out), .out_avl(mul_avl)
    );

    float_point_adder #(.LAT(ADD_LAT)) u_add (
        .clk(clk_fast), .rst_n(rst), .en(state == S_ADD),
        .a(acc), .b(prod), .out(add_out), .out_avl(add_avl)
    );

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid && in_ready && chan_ok) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_MUL;
            S_MUL:    state_nx = S_WAIT_M;
            S_WAIT_M: if (mul_avl) state_nx = S_ADD;
            S_ADD:    state_nx = S_WAIT_A;
            S_WAIT_A: if (add_avl) state_nx = last_tap ? S_DONE : S_MUL;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (clr) state_nx = S_IDLE;
    end

    // Coefficients survive clr; writes land only while no computation is running
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) coef[i] <= '0;
        end else if (coef_we && !busy && 32'(coef_addr) < TAPS) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < int'(NCH); c++) begin
                wr_ptr[c] <= '0;
                for (int i = 0; i < int'(DEPTH); i++) dline[c][i] <= '0;
            end
            k         <= '0;
            base      <= '0;
            chan      <= '0;
            sample    <= '0;
            acc       <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < int'(NCH); c++) begin
                wr_ptr[c] <= '0;
                for (int i = 0; i < int'(DEPTH); i++) dline[c][i] <= '0;
            end
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready && chan_ok) begin
                        chan   <= in_chan;
                        sample <= in_data;
                        busy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dline[chan][wr_ptr[chan]] <= sample;
                    base         <= wr_ptr[chan];
                    wr_ptr[chan] <= (wr_ptr[chan] == PW'(TAPS - 1)) ? '0 : wr_ptr[chan] + PW'(1);
                    k            <= '0;
                    acc          <= '0;
                end
                S_WAIT_M: if (mul_avl) prod <= mul_out;
                S_WAIT_A: begin
                    if (add_avl) begin
                        acc <= add_out;
                        if (!last_tap) k <= k + PW'(1);
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                    out_chan  <= chan;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_tdm.sv
// Scoreboard bench for fir_filter_tdm: a real-valued float10 reference model predicts each
// result at acceptance; the output monitor pops and compares data, channel and latency.

module tb_fir_filter_tdm;
    localparam int unsigned TAPS     = 4;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned MUL_LAT  = 3;
    localparam int unsigned ADD_LAT  = 2;
    localparam int          LAT_EXP  = 2 + TAPS * (2 + MUL_LAT + ADD_LAT);

    typedef struct {
        int         ch;
        logic [9:0] data;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_chan = '0;
    logic [9:0] in_data = '0;
    logic       coef_we = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [9:0] coef_data = '0;
    logic       out_valid;
    logic [1:0] out_chan;
    logic [9:0] out_data;
    logic       busy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] coef_m [TAPS];
    logic [9:0] hist [CHANNELS][TAPS];

    fir_filter_tdm #(.TAPS(TAPS), .CHANNELS(CHANNELS), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
        .clk_fast(clk), .rst(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic real to_real(input logic [9:0] f);
        real v;
        int  e;
        if (f[8:5] == 4'd0) return 0.0;
        v = (32.0 + real'(int'(f[4:0]))) / 32.0;
        e = int'(f[8:5]) - 7;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[9] ? -v : v;
    endfunction

    function automatic logic [9:0] from_real(input real r);
        logic s;
        real  a;
        int   e;
        if (r == 0.0) return 10'h000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 7;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        if (e < 1) return 10'h000;
        if (e > 15) return {s, 4'hF, 5'h1F};
        return {s, 4'(e), 5'($rtoi((a - 1.0) * 32.0))};
    endfunction

    function automatic logic [9:0] model_y(input int ch);
        logic [9:0] acc = 10'h000;
        for (int k = 0; k < int'(TAPS); k++)
            acc = from_real(to_real(acc) + to_real(from_real(to_real(coef_m[k]) * to_real(hist[ch][k]))));
        return acc;
    endfunction

    task automatic clear_model(input bit coefs_too);
        for (int c = 0; c < int'(CHANNELS); c++)
            for (int k = 0; k < int'(TAPS); k++) hist[c][k] = 10'h000;
        if (coefs_too) for (int k = 0; k < int'(TAPS); k++) coef_m[k] = 10'h000;
    endtask

    task automatic send(input int ch, input logic [9:0] d);
        exp_t e;
        bit   got = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_chan = 2'(ch); in_data = d;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
        end else if (ch < int'(CHANNELS)) begin
            for (int k = int'(TAPS) - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = d;
            e.ch = ch; e.data = model_y(ch); e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] addr, input logic [9:0] d, input bit taken);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = addr; coef_data = d;
        @(negedge clk);
        check("busy_at_coef_write", 32'(busy), taken ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (taken) coef_m[addr] = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_chan", 32'(out_chan), 32'(mon_e.ch));
                check("latency", 32'(cyc - mon_e.acc), 32'(LAT_EXP));
                check("busy_low_at_out", 32'(busy), 0);
                check("in_ready_low_at_out", 32'(in_ready), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        clear_model(1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_chan", 32'(out_chan), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        write_coef(2'd0, 10'h0E0, 1'b1);
        write_coef(2'd1, 10'h100, 1'b1);
        write_coef(2'd2, 10'h0C0, 1'b1);
        write_coef(2'd3, 10'h2E0, 1'b1);

        // Impulse response on channel 0, back-to-back offers stall on in_ready
        send(0, 10'h0E0);
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 1);
        check("in_ready_while_busy", 32'(in_ready), 0);
        for (int i = 0; i < 4; i++) send(0, 10'h000);
        drain();

        // Channel isolation and an out-of-range channel
        for (int i = 0; i < 4; i++) begin
            send(0, (i == 0) ? 10'h0E0 : 10'h000);
            send(1, 10'h000);
        end
        drain();
        send(3, 10'h0E0);
        @(negedge clk);
        check("busy_bad_chan", 32'(busy), 0);
        repeat (40) @(negedge clk);

        // Coefficient write while busy is dropped; in idle it lands
        send(2, 10'h0E0);
        write_coef(2'd0, 10'h100, 1'b0);
        drain();
        write_coef(2'd0, 10'h100, 1'b1);
        send(1, 10'h0E0);
        drain();
        write_coef(2'd0, 10'h0E0, 1'b1);

        // clr aborts a computation and zeroes history
        send(1, 10'h0E0);
        repeat (5) @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check("in_ready_during_clr", 32'(in_ready), 0);
        check("busy_before_clr_edge", 32'(busy), 1);
        @(posedge clk); #1;
        clr = 1'b0;
        exp_q.delete();
        clear_model(1'b0);
        @(negedge clk);
        check("in_ready_after_clr", 32'(in_ready), 1);
        check("busy_after_clr", 32'(busy), 0);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) send(0, 10'h0E0);
        drain();

        // Asynchronous reset in the middle of a computation
        send(2, 10'h0E0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_busy", 32'(busy), 0);
        exp_q.delete();
        clear_model(1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 1);
        send(0, 10'h0E0);
        send(0, 10'h100);
        drain();

        // Random coefficients, data and channels against the ordered-accumulation model
        for (int k = 0; k < int'(TAPS); k++) write_coef(2'(k), 10'($urandom_range(0, 1023)), 1'b1);
        for (int i = 0; i < 24; i++) send(int'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
